// File: rtl/tb_stream_pkg.sv
// Shared types and helpers for the simlib stream arbiters.
// Holds the arbiter state encoding and the source-index width helper.
package tb_stream_pkg;

  typedef enum logic {IDLE, BURST} tb_arb_state_t;

  function automatic int src_idx_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tb_rr_pick.sv
// Rotate-priority picker: first requester at or above ptr, with wrap.
// Purely combinational; shared by the simlib arbiters.
module tb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          pick_vld,
  output logic [IW-1:0] pick_idx
);

  // scan offsets high to low so the smallest offset from ptr wins
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tb_stream_arb.sv
// Round-robin burst arbiter sharing one valid/ready sink between sources.
// Define TB_STREAM_ARB_TRACE_EN for a handshake trace and protocol checks.
module tb_stream_arb
  import tb_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_SRC    = 2,
  parameter  int LOCK_LEN   = 1,
  localparam int IW         = src_idx_w(NUM_SRC),
  localparam int CW         = $clog2(LOCK_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_dvld_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_ddat_i,
  input  logic [NUM_SRC-1:0]            src_finish_i,
  output logic [NUM_SRC-1:0]            src_drdy_o,
  output logic                          dvld_o,
  output logic [DATA_WIDTH-1:0]         ddat_o,
  output logic [IW-1:0]                 src_id_o,
  input  logic                          drdy_i,
  output logic                          finish_o
);

  tb_arb_state_t         state, state_nxt;
  logic [IW-1:0]         rr_ptr, ptr_nxt;
  logic [IW-1:0]         grant, grant_nxt;
  logic [CW-1:0]         beat_cnt, cnt_nxt;
  logic                  load_en;
  logic                  xfer;
  logic                  last;
  logic                  pick_vld;
  logic [IW-1:0]         pick_idx;
  logic [IW-1:0]         after_grant;
  logic [DATA_WIDTH-1:0] gdat;

  assign load_en     = !dvld_o || drdy_i;
  assign xfer        = (state == BURST) && src_dvld_i[grant] && load_en;
  assign last        = beat_cnt == CW'(LOCK_LEN - 1);
  assign after_grant = (grant == IW'(NUM_SRC - 1)) ? '0 : grant + IW'(1);

  tb_rr_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req      (src_dvld_i & ~src_finish_i),
    .ptr      (rr_ptr),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  // data lane of the granted source
  always_comb begin
    gdat = src_ddat_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  end

  // only the granted source sees ready, and only when the stage can load
  always_comb begin
    src_drdy_o = '0;
    if (state == BURST && load_en) src_drdy_o[grant] = 1'b1;
  end

  // arbitration next-state: pick in IDLE, count beats or release in BURST
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = rr_ptr;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (xfer) begin
          cnt_nxt = beat_cnt + CW'(1);
          if (last) begin
            ptr_nxt   = after_grant;
            state_nxt = IDLE;
          end
        end else if (src_finish_i[grant]) begin
          ptr_nxt   = after_grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // arbitration state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= ptr_nxt;
      grant    <= grant_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  // one-entry output stage; refills in the cycle it drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvld_o   <= 1'b0;
      ddat_o   <= '0;
      src_id_o <= '0;
    end else if (xfer) begin
      dvld_o   <= 1'b1;
      ddat_o   <= gdat;
      src_id_o <= grant;
    end else if (drdy_i) begin
      dvld_o   <= 1'b0;
    end
  end

  // sticky finish once all sources are done and the stage is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish_o <= 1'b0;
    end else if (&src_finish_i && !dvld_o && state == IDLE) begin
      finish_o <= 1'b1;
    end
  end

`ifdef TB_STREAM_ARB_TRACE_EN
  logic                  chk_stall;
  logic [DATA_WIDTH-1:0] chk_dat;
  logic [IW-1:0]         chk_id;

  // trace handshakes and flag unstable stalled output or multi-ready
  always @(posedge clk) begin
    if (!reset) begin
      if (dvld_o && drdy_i)
        $display("%0t %m src=%0d data=%h", $time, src_id_o, ddat_o);
      if (chk_stall && !dvld_o)
        $error("dvld_o dropped without drdy_i");
      if (chk_stall && (ddat_o != chk_dat || src_id_o != chk_id))
        $error("output changed while stalled");
      if ($countones(src_drdy_o) > 1)
        $error("more than one src_drdy_o set");
    end
    chk_stall <= !reset && dvld_o && !drdy_i;
    chk_dat   <= ddat_o;
    chk_id    <= src_id_o;
  end
`else
  // no trace or protocol checks in the default build
`endif

endmodule

// File: tb/tb_tb_stream_arb.sv
// Bench for tb_stream_arb: cycle vectors on a LOCK_LEN=1 instance,
// queue-driven ordered/random traffic on a LOCK_LEN=3 instance.
module tb_tb_stream_arb;

  localparam int L3 = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1 = 1'b1;
  logic [1:0]  v1 = '0, f1 = '0;
  logic [15:0] d1 = '0;
  logic        rdy1 = 1'b0;
  logic [1:0]  drdy1;
  logic        vld1, id1, fin1;
  logic [7:0]  dat1;

  logic        rst3 = 1'b1;
  logic [1:0]  v3 = '0, f3 = '0;
  logic [15:0] d3 = '0;
  logic        rdy3 = 1'b0;
  logic [1:0]  drdy3;
  logic        vld3, id3, fin3;
  logic [7:0]  dat3;

  tb_stream_arb #(.DATA_WIDTH(8), .NUM_SRC(2), .LOCK_LEN(1)) dut1 (
    .clk(clk), .reset(rst1), .src_dvld_i(v1), .src_ddat_i(d1),
    .src_finish_i(f1), .src_drdy_o(drdy1), .dvld_o(vld1),
    .ddat_o(dat1), .src_id_o(id1), .drdy_i(rdy1), .finish_o(fin1)
  );

  tb_stream_arb #(.DATA_WIDTH(8), .NUM_SRC(2), .LOCK_LEN(L3)) dut3 (
    .clk(clk), .reset(rst3), .src_dvld_i(v3), .src_ddat_i(d3),
    .src_finish_i(f3), .src_drdy_o(drdy3), .dvld_o(vld3),
    .ddat_o(dat3), .src_id_o(id3), .drdy_i(rdy3), .finish_o(fin3)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic       rst;
    logic [1:0] v;
    logic [1:0] f;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       rdy;
    logic [1:0] e_rdy;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_id;
    logic       e_fin;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(
    input logic rst, input logic [1:0] v, input logic [1:0] f,
    input logic [7:0] a, input logic [7:0] b, input logic rdy,
    input logic [1:0] er, input logic ev, input logic [7:0] ed,
    input logic ei, input logic ef);
    row_t r;
    r.rst = rst; r.v = v; r.f = f; r.d0 = a; r.d1 = b; r.rdy = rdy;
    r.e_rdy = er; r.e_vld = ev; r.e_dat = ed; r.e_id = ei; r.e_fin = ef;
    return r;
  endfunction

  task automatic apply_row(input row_t r, input int idx);
    logic [12:0] got, exp;
    @(negedge clk);
    rst1 = r.rst; v1 = r.v; f1 = r.f; d1 = {r.d1, r.d0}; rdy1 = r.rdy;
    #1;
    got = {drdy1, vld1, r.e_vld ? dat1 : 8'h00,
           r.e_vld ? id1 : 1'b0, fin1};
    exp = {r.e_rdy, r.e_vld, r.e_dat, r.e_id, r.e_fin};
    chk($sformatf("row%0d{rdy,vld,dat,id,fin}", idx), 64'(got), 64'(exp));
  endtask

  typedef struct packed {
    logic [7:0] dat;
    logic       id;
  } beat_t;

  logic [7:0] q0[$], q1[$];
  beat_t      obs[$], expq[$];

  // reference order: bursts of up to L beats, pointer moves past the
  // served source, exhausted sources skipped
  task automatic build_exp(input int L);
    int len[2];
    int pos[2];
    int ptr, s;
    expq.delete();
    len[0] = q0.size(); len[1] = q1.size();
    pos[0] = 0; pos[1] = 0;
    ptr = 0;
    while (pos[0] < len[0] || pos[1] < len[1]) begin
      s = (pos[ptr] < len[ptr]) ? ptr : 1 - ptr;
      for (int k = 0; k < L && pos[s] < len[s]; k++) begin
        if (s == 0) expq.push_back(beat_t'({q0[pos[0]], 1'b0}));
        else        expq.push_back(beat_t'({q1[pos[1]], 1'b1}));
        pos[s]++;
      end
      ptr = 1 - s;
    end
  endtask

  task automatic run_stream(input int rdy_pct, input string tag);
    logic [1:0] hs;
    int         multi, early;
    bit         done;
    build_exp(L3);
    obs.delete();
    multi = 0; early = 0; done = 0;
    @(negedge clk);
    rst3 = 1'b1; v3 = '0; f3 = '0; rdy3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      v3[0] = q0.size() != 0;
      v3[1] = q1.size() != 0;
      f3    = ~v3;
      d3    = {v3[1] ? q1[0] : 8'h00, v3[0] ? q0[0] : 8'h00};
      rdy3  = $urandom_range(99) < rdy_pct;
      #1;
      if ($countones(drdy3) > 1) multi++;
      if (fin3) begin
        if (obs.size() != expq.size() || vld3) early++;
        done = 1;
      end else begin
        hs = drdy3 & v3;
        if (vld3 && rdy3) obs.push_back(beat_t'({dat3, id3}));
        @(posedge clk);
        if (hs[0]) void'(q0.pop_front());
        if (hs[1]) void'(q1.pop_front());
        @(negedge clk);
      end
    end
    chk({tag, " finish_reached"}, 64'(done), 64'(1));
    chk({tag, " beat_count"}, 64'(obs.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < obs.size())
        chk($sformatf("%s beat%0d{dat,id}", tag, i),
            64'(obs[i]), 64'(expq[i]));
    end
    chk({tag, " multi_ready"}, 64'(multi), 64'(0));
    chk({tag, " early_finish"}, 64'(early), 64'(0));
  endtask

  initial begin
    // two sources, LOCK_LEN=1, alternating beats and finish
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hA0, 8'hB0, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hA0, 8'hB0, 1, 2'b01, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hA1, 8'hB0, 1, 2'b00, 1, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hA1, 8'hB0, 1, 2'b10, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hA1, 8'hB1, 1, 2'b00, 1, 8'hB0, 1, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hA1, 8'hB1, 1, 2'b01, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h00, 8'hB1, 1, 2'b00, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(0, 2'b10, 2'b01, 8'h00, 8'hB1, 1, 2'b10, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 1, 8'hB1, 1, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 1));
    // backpressure: 5A held for four stalled cycles
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5A, 8'h00, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5A, 8'h00, 0, 2'b01, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5B, 8'h00, 0, 2'b00, 1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5B, 8'h00, 0, 2'b00, 1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5B, 8'h00, 0, 2'b00, 1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5B, 8'h00, 0, 2'b00, 1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'h5B, 8'h00, 1, 2'b01, 1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b00, 1, 8'h5B, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0));
    // granted src1 drops valid for three cycles, grant held
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hC0, 8'hD0, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'hC0, 8'h00, 1, 2'b10, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'hC0, 8'h00, 1, 2'b10, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 8'hC0, 8'h00, 1, 2'b10, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hC0, 8'hD0, 1, 2'b10, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hC0, 8'hD1, 1, 2'b00, 1, 8'hD0, 1, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hC0, 8'hD1, 1, 2'b01, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hC1, 8'hD1, 0, 2'b00, 1, 8'hC0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hC1, 8'hD1, 0, 2'b00, 1, 8'hC0, 0, 0));
    // async reset mid-cycle during a stalled burst
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'hC1, 8'hD1, 0, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hE0, 8'hF0, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hE0, 8'hF0, 1, 2'b01, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 8'hE1, 8'hF0, 1, 2'b00, 1, 8'hE0, 0, 0));
    // everything finished from the start
    tbl.push_back(mk(1, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 2'b11, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 1));

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // LOCK_LEN=3: src0 five beats, src1 two beats
    q0.delete(); q1.delete();
    for (int i = 0; i < 5; i++) q0.push_back(8'(8'h00 + i));
    for (int i = 0; i < 2; i++) q1.push_back(8'(8'h10 + i));
    run_stream(100, "lock3");

    // random lengths, data and sink backpressure
    for (int t = 0; t < 8; t++) begin
      int n0, n1;
      q0.delete(); q1.delete();
      n0 = $urandom_range(7);
      n1 = $urandom_range(7);
      for (int i = 0; i < n0; i++) q0.push_back(8'($urandom_range(255)));
      for (int i = 0; i < n1; i++) q1.push_back(8'($urandom_range(255)));
      run_stream(30 + $urandom_range(70), $sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
